// File: rtl/alu_control_pkg.sv
// Shared encodings for the ALU control decoder: ALUOp classes,
// R-type function codes (low nibble) and datapath ALU operation selects.
package alu_control_pkg;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_RSVD  = 2'b11;

  localparam logic [3:0] FN_ADD = 4'b0000;
  localparam logic [3:0] FN_SUB = 4'b0010;
  localparam logic [3:0] FN_AND = 4'b0100;
  localparam logic [3:0] FN_OR  = 4'b0101;
  localparam logic [3:0] FN_NOR = 4'b0111;
  localparam logic [3:0] FN_SLT = 4'b1010;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;

endpackage

// File: rtl/alu_control_decode.sv
// Combinational decode of ALUOp and Funct into an ALU operation select.
// Unsupported combinations fall back to add and raise illegal.
module alu_control_decode
  import alu_control_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  output logic [3:0] op,
  output logic       illegal
);

  always_comb begin
    op      = OP_ADD;
    illegal = 1'b0;
    case (alu_op)
      ALUOP_ADD: op = OP_ADD;
      ALUOP_SUB: op = OP_SUB;
      ALUOP_RTYPE: begin
        // only the low nibble selects the operation; funct[5:4] are don't-care
        case (funct[3:0])
          FN_ADD:  op = OP_ADD;
          FN_SUB:  op = OP_SUB;
          FN_AND:  op = OP_AND;
          FN_OR:   op = OP_OR;
          FN_NOR:  op = OP_NOR;
          FN_SLT:  op = OP_SLT;
          default: begin
            op      = OP_ADD;
            illegal = 1'b1;
          end
        endcase
      end
      default: begin
        op      = OP_ADD;
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/alu_control.sv
// ALU control: registers the decoded operation select and illegal flag,
// and keeps a sticky record of any illegal decode until reset.
module alu_control
  import alu_control_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] ALUOp,
  input  logic [5:0] Funct,
  output logic [3:0] Operation,
  output logic       Illegal,
  output logic       IllegalSeen
);

  logic [3:0] dec_op;
  logic       dec_illegal;

  alu_control_decode u_decode (
    .alu_op  (ALUOp),
    .funct   (Funct),
    .op      (dec_op),
    .illegal (dec_illegal)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      Operation   <= OP_ADD;
      Illegal     <= 1'b0;
      IllegalSeen <= 1'b0;
    end else begin
      Operation <= dec_op;
      Illegal   <= dec_illegal;
      if (dec_illegal)
        IllegalSeen <= 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_control.sv
// Scoreboard bench for alu_control: stimulus pushes expected results from a
// table-driven reference model; a monitor pops and compares after each edge.
module tb_alu_control;

  logic       clk;
  logic       reset;
  logic [1:0] ALUOp;
  logic [5:0] Funct;
  logic [3:0] Operation;
  logic       Illegal;
  logic       IllegalSeen;

  alu_control dut (
    .clk         (clk),
    .reset       (reset),
    .ALUOp       (ALUOp),
    .Funct       (Funct),
    .Operation   (Operation),
    .Illegal     (Illegal),
    .IllegalSeen (IllegalSeen)
  );

  typedef struct {
    logic [3:0] op;
    logic       ill;
    logic       seen;
  } exp_t;

  exp_t       sb_q[$];
  logic [3:0] rtab[int];
  logic       model_seen;
  exp_t       last_exp;
  int         checks;
  int         failures;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: ALUOp class lookup, then R-type table keyed by Funct low nibble.
  task automatic model(input logic [1:0] a, input logic [5:0] f,
                       output logic [3:0] op, output logic ill);
    int key;
    key = int'(f % 16);
    op  = 4'b0010;
    ill = 1'b0;
    if (a == 2'd0) op = 4'b0010;
    else if (a == 2'd1) op = 4'b0110;
    else if (a == 2'd2) begin
      if (rtab.exists(key)) op = rtab[key];
      else ill = 1'b1;
    end else ill = 1'b1;
  endtask

  task automatic push_exp(input logic [1:0] a, input logic [5:0] f);
    exp_t e;
    model(a, f, e.op, e.ill);
    model_seen = model_seen | e.ill;
    e.seen = model_seen;
    sb_q.push_back(e);
  endtask

  task automatic drive(input logic [1:0] a, input logic [5:0] f);
    @(negedge clk);
    ALUOp = a;
    Funct = f;
    push_exp(a, f);
  endtask

  // Monitor: the block produces a result every edge while out of reset.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!reset && sb_q.size() > 0) begin
        exp_t e;
        e = sb_q.pop_front();
        last_exp = e;
        check("operation", Operation, e.op);
        check("illegal", {3'b0, Illegal}, {3'b0, e.ill});
        check("illegal_seen", {3'b0, IllegalSeen}, {3'b0, e.seen});
      end
    end
  end

  initial begin
    checks     = 0;
    failures   = 0;
    model_seen = 1'b0;
    rtab[0]  = 4'b0010;
    rtab[2]  = 4'b0110;
    rtab[4]  = 4'b0000;
    rtab[5]  = 4'b0001;
    rtab[7]  = 4'b1100;
    rtab[10] = 4'b0111;

    reset = 1'b1;
    ALUOp = 2'b00;
    Funct = 6'b000000;
    #1;
    check("reset_op", Operation, 4'b0010);
    check("reset_ill", {3'b0, Illegal}, 4'b0);
    check("reset_seen", {3'b0, IllegalSeen}, 4'b0);
    @(negedge clk);
    reset = 1'b0;

    drive(2'b00, 6'b100111);
    drive(2'b00, 6'b000011);
    drive(2'b01, 6'b101010);

    drive(2'b10, 6'b000000);
    drive(2'b10, 6'b000010);
    drive(2'b10, 6'b000100);
    drive(2'b10, 6'b000101);
    drive(2'b10, 6'b000111);
    drive(2'b10, 6'b001010);
    drive(2'b10, 6'b100010);

    drive(2'b10, 6'b000011);
    drive(2'b10, 6'b000100);
    drive(2'b11, 6'b000000);
    drive(2'b01, 6'b000000);

    // Inputs changed mid-cycle must not reach the outputs before the next edge.
    drive(2'b10, 6'b000101);
    @(posedge clk);
    #3;
    ALUOp = 2'b10;
    Funct = 6'b000111;
    push_exp(2'b10, 6'b000111);
    #1;
    check("latency_hold_op", Operation, 4'b0001);
    @(posedge clk);
    #2;
    check("latency_update_op", Operation, 4'b1100);

    // Asynchronous reset mid-cycle while a subtract is registered.
    drive(2'b01, 6'b101010);
    @(posedge clk);
    #3;
    check("pre_reset_op", Operation, 4'b0110);
    reset = 1'b1;
    #1;
    check("async_reset_op", Operation, 4'b0010);
    check("async_reset_ill", {3'b0, Illegal}, 4'b0);
    check("async_reset_seen", {3'b0, IllegalSeen}, 4'b0);
    model_seen = 1'b0;
    @(posedge clk);
    #1;
    check("held_reset_op", Operation, 4'b0010);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 300; i++) begin
      logic [1:0] a;
      logic [5:0] f;
      a = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0) a = (a == 2'b11) ? 2'b10 : a;
      f = 6'($urandom);
      drive(a, f);
    end

    @(posedge clk);
    #3;
    check("scoreboard_drained", 4'(sb_q.size()), 4'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, checks=%0d", checks);
    $fatal(1);
  end

endmodule
